// File: rtl/tree_mgt_arbiter.sv
// tree_mgt_arbiter: shares one tree-space token manager between NB_REQ engines.
// Allocations run through a 3-state FSM (IDLE/ALLOC/GRANT).
// Frees run through an independent single-entry buffer.
// Each path has its own round-robin pointer.
// A saturating usage counter tracks live tokens; a sticky flag records frees seen at zero.
module tree_mgt_arbiter #(
  parameter int TOKEN_WIDTH = 8,
  parameter int NB_REQ      = 2
) (
  input  logic                          aclk,
  input  logic                          srst,
  input  logic [NB_REQ-1:0]             eng_req_valid,
  output logic [NB_REQ-1:0]             eng_req_ready,
  output logic [TOKEN_WIDTH-1:0]        eng_req_addr,
  input  logic [NB_REQ-1:0]             eng_free_valid,
  output logic [NB_REQ-1:0]             eng_free_ready,
  input  logic [NB_REQ*TOKEN_WIDTH-1:0] eng_free_addr,
  output logic                          mgt_req_valid,
  input  logic                          mgt_req_ready,
  input  logic [TOKEN_WIDTH-1:0]        mgt_req_addr,
  output logic                          mgt_free_valid,
  input  logic                          mgt_free_ready,
  output logic [TOKEN_WIDTH-1:0]        mgt_free_addr,
  input  logic                          mgt_full,
  output logic [TOKEN_WIDTH:0]          tokens_used,
  output logic                          free_err
);
  localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam logic [TOKEN_WIDTH:0] USED_MAX = {1'b1, {TOKEN_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ALLOC, GRANT} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          win_q, win_d;
  logic [PW-1:0]          aptr_q, aptr_d;
  logic [PW-1:0]          fptr_q, fptr_d;
  logic [TOKEN_WIDTH-1:0] tok_q, tok_d;
  logic [TOKEN_WIDTH-1:0] fbuf_q, fbuf_d;
  logic                   fbuf_full_q, fbuf_full_d;
  logic [TOKEN_WIDTH:0]   used_q, used_d;
  logic                   err_q, err_d;

  logic                   grant;
  logic                   free_hs;
  logic [PW-1:0]          fwin;
  logic [NB_REQ-1:0][TOKEN_WIDTH-1:0] free_addr_arr;

  assign free_addr_arr = eng_free_addr;

  // First active request at or after ptr, wrapping modulo NB_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [NB_REQ-1:0] v,
                                            input logic [PW-1:0]     ptr);
    logic [PW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      idx = (int'(ptr) + k) % NB_REQ;
      if (!found && v[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  // Pointer successor with wrap at NB_REQ-1 (NB_REQ need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NB_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Allocation FSM: pick a winner, hold the manager request, then present the token for one cycle.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    tok_d         = tok_q;
    aptr_d        = aptr_q;
    mgt_req_valid = 1'b0;
    eng_req_ready = '0;
    eng_req_addr  = '0;
    grant         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eng_req_valid && !mgt_full) begin
          win_d   = rr_pick(eng_req_valid, aptr_q);
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        mgt_req_valid = 1'b1;
        if (mgt_req_ready) begin
          tok_d   = mgt_req_addr;
          state_d = GRANT;
        end
      end
      GRANT: begin
        for (int i = 0; i < NB_REQ; i++) eng_req_ready[i] = (win_q == PW'(i));
        eng_req_addr = tok_q;
        grant        = 1'b1;
        aptr_d       = ptr_inc(win_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Free buffer: accept one engine while empty, present to the manager while full.
  always_comb begin
    fbuf_d         = fbuf_q;
    fbuf_full_d    = fbuf_full_q;
    fptr_d         = fptr_q;
    eng_free_ready = '0;
    mgt_free_valid = fbuf_full_q;
    mgt_free_addr  = fbuf_full_q ? fbuf_q : '0;
    fwin           = rr_pick(eng_free_valid, fptr_q);
    if (fbuf_full_q) begin
      if (mgt_free_ready) fbuf_full_d = 1'b0;
    end else if (|eng_free_valid && !srst) begin
      // The acceptance is withheld during reset so that no engine sees its free taken and then lost.
      for (int i = 0; i < NB_REQ; i++) eng_free_ready[i] = (fwin == PW'(i));
      fbuf_d      = free_addr_arr[fwin];
      fbuf_full_d = 1'b1;
      fptr_d      = ptr_inc(fwin);
    end
  end

  // Usage counter: a grant and a free in the same cycle cancel; saturates at both ends.
  always_comb begin
    free_hs = mgt_free_valid & mgt_free_ready;
    used_d  = used_q;
    err_d   = err_q;
    if (free_hs && used_q == '0) err_d = 1'b1;
    if (grant && !free_hs) begin
      if (used_q != USED_MAX) used_d = used_q + 1'b1;
    end else if (free_hs && !grant) begin
      if (used_q != '0) used_d = used_q - 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      aptr_q      <= '0;
      fptr_q      <= '0;
      tok_q       <= '0;
      fbuf_q      <= '0;
      fbuf_full_q <= 1'b0;
      used_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      aptr_q      <= aptr_d;
      fptr_q      <= fptr_d;
      tok_q       <= tok_d;
      fbuf_q      <= fbuf_d;
      fbuf_full_q <= fbuf_full_d;
      used_q      <= used_d;
      err_q       <= err_d;
    end
  end

  assign tokens_used = used_q;
  assign free_err    = err_q;

endmodule

// File: tb/tb_tree_mgt_arbiter.sv
// Bench for tree_mgt_arbiter.
// Directed scenarios are followed by a randomized run.
// Every cycle is compared against a transaction-level reference model.
module tb_tree_mgt_arbiter;
  localparam int TW = 8;
  localparam int N  = 2;

  logic              aclk = 1'b0;
  logic              srst = 1'b1;
  logic [N-1:0]      eng_req_valid, eng_req_ready, eng_free_valid, eng_free_ready;
  logic [TW-1:0]     eng_req_addr, mgt_req_addr, mgt_free_addr;
  logic [N*TW-1:0]   eng_free_addr;
  logic              mgt_req_valid, mgt_req_ready, mgt_free_valid, mgt_free_ready, mgt_full;
  logic [TW:0]       tokens_used;
  logic              free_err;

  // Engine / manager stimulus state.
  logic [N-1:0]  req_pend  = '0;
  logic [N-1:0]  free_pend = '0;
  logic [N-1:0]  auto_req  = '0;
  logic [TW-1:0] free_tok [N];
  logic [TW-1:0] next_tok  = 8'h01;

  // Reference model state.
  bit            have_txn, got_tok, buf_full, exp_err;
  int            txn_eng, aptr, fptr, exp_used;
  logic [TW-1:0] txn_tok, buf_addr;
  logic [N-1:0]  prev_req, prev_rdy, prev_free, prev_frdy;
  int            n_grants, cyc_no, last_gnt_cyc;
  int            grant_log[$];
  logic [TW-1:0] freed_q[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  assign eng_req_valid  = req_pend;
  assign eng_free_valid = free_pend;
  assign mgt_req_addr   = next_tok;
  always_comb begin
    eng_free_addr = '0;
    for (int i = 0; i < N; i++) eng_free_addr[i*TW +: TW] = free_tok[i];
  end

  tree_mgt_arbiter #(.TOKEN_WIDTH(TW), .NB_REQ(N)) dut (
    .aclk(aclk), .srst(srst),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_req_addr(eng_req_addr),
    .eng_free_valid(eng_free_valid), .eng_free_ready(eng_free_ready), .eng_free_addr(eng_free_addr),
    .mgt_req_valid(mgt_req_valid), .mgt_req_ready(mgt_req_ready), .mgt_req_addr(mgt_req_addr),
    .mgt_free_valid(mgt_free_valid), .mgt_free_ready(mgt_free_ready), .mgt_free_addr(mgt_free_addr),
    .mgt_full(mgt_full), .tokens_used(tokens_used), .free_err(free_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Round-robin choice from the rule: first set bit at or after p, wrapping.
  function automatic int rr(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    srst = 1'b1;
    req_pend = '0; free_pend = '0; auto_req = '0;
    mgt_req_ready = 1'b0; mgt_free_ready = 1'b0; mgt_full = 1'b0;
    @(posedge aclk); #1;
    srst = 1'b0;
    have_txn = 0; got_tok = 0; buf_full = 0; exp_err = 0;
    aptr = 0; fptr = 0; exp_used = 0; next_tok = 8'h01;
    n_grants = 0; grant_log.delete(); freed_q.delete();
    prev_req = '0; prev_rdy = '0; prev_free = '0; prev_frdy = '0;
  endtask

  // One clock: settle inputs, check against the model, advance the model, cross the edge.
  task automatic cyc();
    int           w, gnt_eng, acc_eng;
    bit           g, d, mhs;
    logic [N-1:0] exp_fr;
    #2;
    chk("tokens_used", 32'(tokens_used), 32'(exp_used));
    chk("free_err", 32'(free_err), 32'(exp_err));
    for (int i = 0; i < N; i++) begin
      if (prev_req[i] && !prev_rdy[i])
        assert (req_pend[i]) else $error("engine %0d dropped req valid before ready", i);
      if (prev_free[i] && !prev_frdy[i])
        assert (free_pend[i]) else $error("engine %0d dropped free valid before ready", i);
    end
    g = 0; d = 0; mhs = 0; gnt_eng = -1; acc_eng = -1;

    // Allocation transaction model.
    if (!have_txn) begin
      chk("idle_alloc_outs", 32'({mgt_req_valid, eng_req_ready, eng_req_addr}), 32'(0));
      if (req_pend != '0 && !mgt_full) begin
        have_txn = 1; got_tok = 0; txn_eng = rr(req_pend, aptr);
      end
    end else if (!got_tok) begin
      chk("alloc_outs", 32'({mgt_req_valid, eng_req_ready, eng_req_addr}), 32'(1) << (N + TW));
      if (mgt_req_ready) begin got_tok = 1; txn_tok = next_tok; mhs = 1; end
    end else begin
      chk("grant_ready", 32'(eng_req_ready), 32'(1) << txn_eng);
      chk("grant_addr", 32'(eng_req_addr), 32'(txn_tok));
      chk("grant_mreq", 32'(mgt_req_valid), 32'(0));
      g = 1; gnt_eng = txn_eng; have_txn = 0; aptr = (txn_eng + 1) % N;
    end

    // Free buffer model.
    if (!buf_full) begin
      w = rr(free_pend, fptr);
      exp_fr = '0;
      if (w >= 0) exp_fr[w] = 1'b1;
      chk("free_accept", 32'({mgt_free_valid, eng_free_ready}), 32'(exp_fr));
      if (w >= 0) begin buf_full = 1; buf_addr = free_tok[w]; fptr = (w + 1) % N; acc_eng = w; end
    end else begin
      chk("free_present", 32'({mgt_free_valid, eng_free_ready, mgt_free_addr}),
          (32'(1) << (N + TW)) | 32'(buf_addr));
      if (mgt_free_ready) begin buf_full = 0; d = 1; freed_q.push_back(buf_addr); end
    end

    // Usage accounting.
    if (d && exp_used == 0) exp_err = 1;
    if (g && !d) exp_used = (exp_used == (1 << TW)) ? exp_used : exp_used + 1;
    else if (d && !g && exp_used > 0) exp_used = exp_used - 1;
    if (g) begin n_grants++; grant_log.push_back(gnt_eng); last_gnt_cyc = cyc_no; end

    prev_req = req_pend; prev_rdy = eng_req_ready;
    prev_free = free_pend; prev_frdy = eng_free_ready;
    @(posedge aclk); #1;
    cyc_no++;
    if (gnt_eng >= 0) req_pend[gnt_eng] = auto_req[gnt_eng];
    if (acc_eng >= 0) free_pend[acc_eng] = 1'b0;
    if (mhs) next_tok = next_tok + 8'h01;
  endtask

  // Run until the grant count reaches target, or flag a timeout.
  task automatic run_grants(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (n_grants < target && k < budget) begin cyc(); k++; end
    if (n_grants < target) chk({tag, "_timeout"}, 32'(n_grants), 32'(target));
  endtask

  initial begin
    int t0, k;
    cyc_no = 0;
    for (int i = 0; i < N; i++) free_tok[i] = '0;
    mgt_req_ready = 1'b0; mgt_free_ready = 1'b0; mgt_full = 1'b0;

    // Reset state: every output 0.
    do_reset();
    #2;
    chk("reset_outs", {mgt_req_valid, eng_req_ready, eng_req_addr, eng_free_ready,
                       mgt_free_valid, mgt_free_addr, tokens_used, free_err}, 32'(0));

    // Reset in the middle of ALLOC drops the request.
    req_pend = 2'b01;
    repeat (3) cyc();
    chk("mid_alloc_no_grant", 32'(n_grants), 32'(0));
    chk("mid_alloc_mreq", 32'(mgt_req_valid), 32'(1));
    do_reset();
    #2;
    chk("mid_alloc_rst_outs", 32'({mgt_req_valid, eng_req_ready, eng_req_addr}), 32'(0));
    repeat (4) cyc();
    chk("mid_alloc_after", 32'(n_grants), 32'(0));

    // Round-robin fairness: tokens 1..4 go to engines 0,1,0,1.
    do_reset();
    auto_req = 2'b11; req_pend = 2'b11; mgt_req_ready = 1'b1;
    run_grants("rr", 4, 40);
    #2;
    chk("rr_used", 32'(tokens_used), 32'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("rr_order", 32'(grant_log[i]), 32'(i % 2));

    // mgt_full gates allocation; grant two cycles after it drops.
    do_reset();
    mgt_full = 1'b1; mgt_req_ready = 1'b1; req_pend = 2'b10;
    repeat (10) cyc();
    chk("full_no_grant", 32'(n_grants), 32'(0));
    mgt_full = 1'b0;
    t0 = cyc_no;
    run_grants("full", 1, 10);
    chk("full_latency", 32'(last_gnt_cyc - t0), 32'(2));
    if (grant_log.size() > 0) chk("full_winner", 32'(grant_log[0]), 32'(1));

    // Free buffering: engine1 waits behind a stalled 0x05; frees at zero set free_err.
    do_reset();
    free_tok[0] = 8'h05; free_tok[1] = 8'h3C; free_pend = 2'b11;
    repeat (5) cyc();
    chk("fbuf_addr_held", 32'(mgt_free_addr), 32'h05);
    mgt_free_ready = 1'b1;
    k = 0;
    while (freed_q.size() < 2 && k < 10) begin cyc(); k++; end
    mgt_free_ready = 1'b0;
    chk("fbuf_count", 32'(freed_q.size()), 32'(2));
    if (freed_q.size() == 2) begin
      chk("fbuf_first", 32'(freed_q[0]), 32'h05);
      chk("fbuf_second", 32'(freed_q[1]), 32'h3C);
    end
    repeat (5) cyc();
    #2;
    chk("err_sticky", 32'(free_err), 32'(1));
    chk("err_used_zero", 32'(tokens_used), 32'(0));
    do_reset();
    #2;
    chk("err_cleared", 32'(free_err), 32'(0));

    // Grant and free complete together at tokens_used == 3.
    auto_req = 2'b01; req_pend = 2'b01; mgt_req_ready = 1'b1;
    k = 0;
    while (n_grants < 3 && k < 30) begin
      cyc(); k++;
      if (n_grants == 2) auto_req = 2'b00;
    end
    chk("sim_pre_used", 32'(tokens_used), 32'(3));
    req_pend = 2'b01; free_pend = 2'b10; free_tok[1] = 8'h77;
    cyc();
    cyc();
    mgt_free_ready = 1'b1;
    cyc();
    mgt_free_ready = 1'b0;
    #2;
    chk("sim_grants", 32'(n_grants), 32'(4));
    chk("sim_frees", 32'(freed_q.size()), 32'(1));
    chk("sim_used", 32'(tokens_used), 32'(3));

    // Saturation at 2^TW.
    do_reset();
    auto_req = 2'b11; req_pend = 2'b11; mgt_req_ready = 1'b1;
    run_grants("sat", (1 << TW) + 2, 1000);
    #2;
    chk("sat_used", 32'(tokens_used), 32'(1 << TW));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      mgt_req_ready  = ($urandom_range(0, 9) < 7);
      mgt_free_ready = ($urandom_range(0, 9) < 5);
      mgt_full       = ($urandom_range(0, 9) < 2);
      for (int i = 0; i < N; i++) begin
        if (!req_pend[i] && $urandom_range(0, 9) < 3) req_pend[i] = 1'b1;
        if (!free_pend[i] && $urandom_range(0, 9) < 3) begin
          free_pend[i] = 1'b1;
          free_tok[i]  = 8'($urandom);
        end
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
